// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
//
// Initiator side of a combinational ALU. Accepts one command on a valid/ready
// port, registers the operands and func code onto the ALU inputs, captures the
// ALU result one cycle later and returns it on a valid/ready response port.
// Only one command is in flight at a time. An illegal func code (11..15) skips
// the ALU and returns an error response.
//
// Optional feature (macro ALU_OVF_STICKY_EN): adds a sticky overflow flag that
// is set when a legal response with overflow is accepted. ovf_clr clears it,
// and a clear wins over a set in the same cycle.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_a, cmd_b, cmd_func       command operands and op code
//   alu_a, alu_b, alu_func       registered operands/op code driven to the ALU
//   alu_y, alu_of                ALU result and overflow flag
//   rsp_valid/rsp_ready          response handshake
//   rsp_y, rsp_of, rsp_err       captured result, overflow, illegal-func flag
//   op_cnt                       completed responses, modulo 2^CNT_W
//   ovf_clr, ovf_sticky          sticky overflow (ALU_OVF_STICKY_EN only)
// -----------------------------------------------------------------------------
module alu_op_issuer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_func,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_of,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_cnt
`ifdef ALU_OVF_STICKY_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  // Highest legal op code (sra); everything above is rejected.
  localparam logic [3:0] FUNC_MAX_LEGAL = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [3:0]       alu_func_q, alu_func_d;
  logic [WIDTH-1:0] rsp_y_q,    rsp_y_d;
  logic             rsp_of_q,   rsp_of_d;
  logic             rsp_err_q,  rsp_err_d;
  logic [CNT_W-1:0] op_cnt_q,   op_cnt_d;

  logic rsp_fire;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred; blocking '=' is correct in
  // combinational logic.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_func_d = alu_func_q;
    rsp_y_d    = rsp_y_q;
    rsp_of_d   = rsp_of_q;
    rsp_err_d  = rsp_err_q;
    op_cnt_d   = op_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_func <= FUNC_MAX_LEGAL) begin
            alu_a_d    = cmd_a;
            alu_b_d    = cmd_b;
            alu_func_d = cmd_func;
            state_d    = ISSUE;
          end else begin
            // ALU inputs keep the last legal command; answer with an error.
            rsp_y_d   = '0;
            rsp_of_d  = 1'b0;
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      ISSUE: begin
        // The ALU has had a full cycle to settle on the registered inputs.
        rsp_y_d   = alu_y;
        rsp_of_d  = alu_of;
        rsp_err_d = 1'b0;
        state_d   = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_cnt_d = op_cnt_q + CNT_W'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      rsp_y_q    <= '0;
      rsp_of_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      op_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      rsp_y_q    <= rsp_y_d;
      rsp_of_q   <= rsp_of_d;
      rsp_err_q  <= rsp_err_d;
      op_cnt_q   <= op_cnt_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_func  = alu_func_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_of    = rsp_of_q;
  assign rsp_err   = rsp_err_q;
  assign op_cnt    = op_cnt_q;

`ifdef ALU_OVF_STICKY_EN
  logic ovf_sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else if (ovf_clr) begin
      ovf_sticky_q <= 1'b0;
    end else if (rsp_fire && !rsp_err_q && rsp_of_q) begin
      ovf_sticky_q <= 1'b1;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
`else
  // Handshake qualifier is only consumed by the sticky flag.
  logic unused_rsp_fire;
  assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
//
// Self-checking bench for alu_op_issuer. Two instances share all stimulus:
// dut (CNT_W=16) and dut2 (CNT_W=2, to observe counter wrap). Each has its own
// behavioural combinational ALU. Expected results are hand-computed constants
// in a vector table, plus directed sequences for backpressure, reset during an
// operation and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_func;
  logic        rsp_ready;

  logic        cmd_ready,  cmd_ready2;
  logic [31:0] alu_a,      alu_a2;
  logic [31:0] alu_b,      alu_b2;
  logic [3:0]  alu_func,   alu_func2;
  logic [31:0] alu_y,      alu_y2;
  logic        alu_of,     alu_of2;
  logic        rsp_valid,  rsp_valid2;
  logic [31:0] rsp_y,      rsp_y2;
  logic        rsp_of,     rsp_of2;
  logic        rsp_err,    rsp_err2;
  logic [15:0] op_cnt;
  logic [1:0]  op_cnt2;
`ifdef ALU_OVF_STICKY_EN
  logic        ovf_clr;
  logic        ovf_sticky, ovf_sticky2;
`endif

  // Behavioural ALU attached to the issuer: returns {of, y}.
  function automatic logic [32:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
    logic [31:0] y;
    logic        of;
    y  = '0;
    of = 1'b0;
    case (f)
      4'd0: begin y = a + b; of = (a[31] == b[31]) && (y[31] != a[31]); end
      4'd1: begin y = a - b; of = (a[31] != b[31]) && (y[31] != a[31]); end
      4'd2:  y = {31'b0, a == b};
      4'd3:  y = {31'b0, a < b};
      4'd4:  y = {31'b0, $signed(a) < $signed(b)};
      4'd5:  y = a & b;
      4'd6:  y = a | b;
      4'd7:  y = a ^ b;
      4'd8:  y = a >> b[4:0];
      4'd9:  y = a << b[4:0];
      4'd10: y = $unsigned($signed(a) >>> b[4:0]);
      default: y = '0;
    endcase
    return {of, y};
  endfunction

  assign {alu_of,  alu_y}  = alu_model(alu_a,  alu_b,  alu_func);
  assign {alu_of2, alu_y2} = alu_model(alu_a2, alu_b2, alu_func2);

  alu_op_issuer #(.WIDTH(32), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_func  (cmd_func),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_y     (alu_y),
    .alu_of    (alu_of),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_of    (rsp_of),
    .rsp_err   (rsp_err),
    .op_cnt    (op_cnt)
`ifdef ALU_OVF_STICKY_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

  alu_op_issuer #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready2),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_func  (cmd_func),
    .alu_a     (alu_a2),
    .alu_b     (alu_b2),
    .alu_func  (alu_func2),
    .alu_y     (alu_y2),
    .alu_of    (alu_of2),
    .rsp_valid (rsp_valid2),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y2),
    .rsp_of    (rsp_of2),
    .rsp_err   (rsp_err2),
    .op_cnt    (op_cnt2)
`ifdef ALU_OVF_STICKY_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic [31:0] exp_y;
    logic        exp_of;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[15];

  // Reference state: last legal command on the ALU ports, responses completed.
  logic [31:0] last_a, last_b;
  logic [3:0]  last_f;
  int          exp_cnt;

  // Applies one command starting at a negedge with rsp_ready held high and
  // returns at the negedge after the response handshake (back in IDLE).
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    check({tag, " cmd_ready"}, 64'(cmd_ready), 64'(1));
    cmd_a     = v.a;
    cmd_b     = v.b;
    cmd_func  = v.func;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " rsp_y"},   64'(rsp_y),   64'(v.exp_y));
    check({tag, " rsp_of"},  64'(rsp_of),  64'(v.exp_of));
    check({tag, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    if (!v.exp_err) begin
      last_a = v.a;
      last_b = v.b;
      last_f = v.func;
    end
    check({tag, " alu_a"},    64'(alu_a),    64'(last_a));
    check({tag, " alu_b"},    64'(alu_b),    64'(last_b));
    check({tag, " alu_func"}, 64'(alu_func), 64'(last_f));
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    check({tag, " rsp_valid_drop"}, 64'(rsp_valid), 64'(0));
    check({tag, " op_cnt"},  64'(op_cnt),  64'(exp_cnt % 65536));
    check({tag, " op_cnt2"}, 64'(op_cnt2), 64'(exp_cnt % 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    vec_t v;

    vecs[0]  = '{32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000, 1'b1, 1'b0, 2};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 4'd1,  32'hFFFF_FFFE, 1'b0, 1'b0, 2};
    vecs[2]  = '{32'h8000_0000, 32'h0000_0001, 4'd1,  32'h7FFF_FFFF, 1'b1, 1'b0, 2};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0005, 4'd2,  32'h0000_0001, 1'b0, 1'b0, 2};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0006, 4'd2,  32'h0000_0000, 1'b0, 1'b0, 2};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 1'b0, 1'b0, 2};
    vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd4,  32'h0000_0001, 1'b0, 1'b0, 2};
    vecs[7]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5,  32'hF000_F000, 1'b0, 1'b0, 2};
    vecs[8]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6,  32'hFFF0_FFF0, 1'b0, 1'b0, 2};
    vecs[9]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd7,  32'h0FF0_0FF0, 1'b0, 1'b0, 2};
    vecs[10] = '{32'h8000_0000, 32'h0000_0024, 4'd8,  32'h0800_0000, 1'b0, 1'b0, 2};
    vecs[11] = '{32'h0000_0001, 32'h0000_001F, 4'd9,  32'h8000_0000, 1'b0, 1'b0, 2};
    vecs[12] = '{32'h8000_0000, 32'h0000_0024, 4'd10, 32'hF800_0000, 1'b0, 1'b0, 2};
    vecs[13] = '{32'h1234_5678, 32'h9ABC_DEF0, 4'hC,  32'h0000_0000, 1'b0, 1'b1, 1};
    vecs[14] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF,  32'h0000_0000, 1'b0, 1'b1, 1};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_func  = '0;
    rsp_ready = 1'b0;
`ifdef ALU_OVF_STICKY_EN
    ovf_clr   = 1'b0;
`endif
    last_a  = '0;
    last_b  = '0;
    last_f  = '0;
    exp_cnt = 0;

    repeat (2) @(negedge clk);
    check("reset cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset alu_a",     64'(alu_a),     64'(0));
    check("reset alu_func",  64'(alu_func),  64'(0));
    check("reset rsp_y",     64'(rsp_y),     64'(0));
    check("reset rsp_err",   64'(rsp_err),   64'(0));
    check("reset op_cnt",    64'(op_cnt),    64'(0));
`ifdef ALU_OVF_STICKY_EN
    check("reset ovf_sticky", 64'(ovf_sticky), 64'(0));
`endif
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors; the illegal ones sit after a legal sra so the
    // retained alu_func is checked as 10.
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef ALU_OVF_STICKY_EN
    check("sticky set", 64'(ovf_sticky), 64'(1));
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("sticky clr", 64'(ovf_sticky), 64'(0));
`endif

    // Backpressure: sub held for 4 cycles with rsp_ready low; a competing
    // command during ISSUE/RESP must be ignored.
    cmd_a     = 32'h0000_0005;
    cmd_b     = 32'h0000_0007;
    cmd_func  = 4'd1;
    cmd_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_a    = 32'hDEAD_BEEF;
    cmd_b    = 32'h0000_0003;
    cmd_func = 4'd0;
    check("bp issue cmd_ready", 64'(cmd_ready), 64'(0));
    check("bp issue rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d rsp_valid", i), 64'(rsp_valid), 64'(1));
      check($sformatf("bp%0d rsp_y", i),     64'(rsp_y),     64'(32'hFFFF_FFFE));
      check($sformatf("bp%0d rsp_of", i),    64'(rsp_of),    64'(0));
      check($sformatf("bp%0d cmd_ready", i), 64'(cmd_ready), 64'(0));
      check($sformatf("bp%0d alu_a", i),     64'(alu_a),     64'(32'h0000_0005));
      check($sformatf("bp%0d op_cnt", i),    64'(op_cnt),    64'(exp_cnt));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    last_a = 32'h0000_0005;
    last_b = 32'h0000_0007;
    last_f = 4'd1;
    check("bp op_cnt", 64'(op_cnt), 64'(exp_cnt));
    check("bp done rsp_valid", 64'(rsp_valid), 64'(0));
    check("bp done cmd_ready", 64'(cmd_ready), 64'(1));

    // Reset while in ISSUE: outputs clear at once, no response afterwards.
    cmd_a     = 32'h1234_5678;
    cmd_b     = 32'h0000_0001;
    cmd_func  = 4'd0;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre-rst state issue", 64'(cmd_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("midrst alu_a",     64'(alu_a),     64'(0));
    check("midrst alu_func",  64'(alu_func),  64'(0));
    check("midrst rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst rsp_y",     64'(rsp_y),     64'(0));
    check("midrst op_cnt",    64'(op_cnt),    64'(0));
    check("midrst cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    rst     = 1'b0;
    exp_cnt = 0;
    last_a  = '0;
    last_b  = '0;
    last_f  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("postrst%0d rsp_valid", i), 64'(rsp_valid), 64'(0));
    end

    // Four back-to-back commands: one response every 3 cycles; dut2 wraps.
    for (int i = 0; i < 4; i++) begin
      v  = vecs[i];
      t0 = cyc;
      run_vec(v, $sformatf("b2b%0d", i));
      check($sformatf("b2b%0d period", i), 64'(cyc - t0), 64'(3));
    end
    check("b2b op_cnt=4",   64'(op_cnt),  64'(4));
    check("b2b op_cnt2=0",  64'(op_cnt2), 64'(0));
    run_vec(vecs[13], "b2b err");
    check("b2b op_cnt2=1",  64'(op_cnt2), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
